// File: rtl/service_protocol_packer_if.sv
// service_protocol_packer_if: start/payload/transmit signals between the packer and its neighbours
// master: reply logic, payload source and SPI transmitter side (the bench drives this side)
// slave:  the packer itself
interface service_protocol_packer_if;
  logic start;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic [7:0] size;
  logic data_rd;
  logic data_vld;
  logic [15:0] data_in;
  logic [15:0] out_data;
  logic out_request;
  logic out_done;
  logic busy;
  logic pkt_done;
  logic pkt_err;
  modport master (
    output start, addr, cmd, size, data_vld, data_in, out_done,
    input data_rd, out_data, out_request, busy, pkt_done, pkt_err
  );
  modport slave (
    input start, addr, cmd, size, data_vld, data_in, out_done,
    output data_rd, out_data, out_request, busy, pkt_done, pkt_err
  );
endinterface

// File: rtl/service_protocol_packer.sv
// service_protocol_packer: frames HEAD1, HEAD2, DATA[size], CRC, NUM and pushes them word by word to the SPI transmitter
// Ports:
//   clk, nRst (synchronous, active low)
//   bus.start/addr/cmd/size      packet request from the reply logic
//   bus.data_rd/data_vld/data_in payload pull from the module
//   bus.out_data/out_request/out_done  push handshake to the SPI transmitter
//   bus.busy/pkt_done/pkt_err    packet status
// Parameters: NUM_INIT (first NUM value), TIMEOUT (only with SP_PACKER_TIMEOUT_EN)
// Optional feature: define SP_PACKER_TIMEOUT_EN to abort a packet whose transmitter or payload source stalls too long
module service_protocol_packer #(
`ifdef SP_PACKER_TIMEOUT_EN
  parameter int TIMEOUT = 255,
`endif
  parameter logic [15:0] NUM_INIT = 16'h0000
) (
  input logic clk,
  input logic nRst,
  service_protocol_packer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HEAD1 = 3'd1;
  localparam logic [2:0] HEAD2 = 3'd2;
  localparam logic [2:0] FETCH = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] CRC = 3'd5;
  localparam logic [2:0] NUM = 3'd6;
  logic [2:0] state;
  logic [7:0] cmdR, sizeR, cnt;
  logic [15:0] crc, num, outData, crcNext;
  logic outRequest, dataRd, busyR, pktDone, accepted, lastWord;
  // out_done counts only after the request cycle of the current word
  assign accepted = !outRequest && bus.out_done;
  assign crcNext = crc + outData;
  assign lastWord = (state == HEAD2) ? (sizeR == 8'd0) : (cnt == sizeR - 8'd1);
`ifdef SP_PACKER_TIMEOUT_EN
  logic [15:0] tmo;
  logic pktErr, waiting;
  assign waiting = (state == FETCH) ? (!dataRd && !bus.data_vld) : (state != IDLE && !outRequest && !bus.out_done);
`endif
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= IDLE;
      outData <= '0;
      outRequest <= 1'b0;
      dataRd <= 1'b0;
      busyR <= 1'b0;
      pktDone <= 1'b0;
      crc <= '0;
      cnt <= '0;
      cmdR <= '0;
      sizeR <= '0;
      // a reset that abandons a packet keeps the sequence number so the peer sees no gap
      num <= busyR ? num : NUM_INIT;
`ifdef SP_PACKER_TIMEOUT_EN
      tmo <= '0;
      pktErr <= 1'b0;
`endif
    end else begin
      outRequest <= 1'b0;
      dataRd <= 1'b0;
      pktDone <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= HEAD1;
          cmdR <= bus.cmd;
          sizeR <= bus.size;
          crc <= '0;
          busyR <= 1'b1;
          outData <= {8'h00, bus.addr};
          outRequest <= 1'b1;
        end
        HEAD1: if (accepted) begin
          state <= HEAD2;
          crc <= crcNext;
          outData <= {sizeR, cmdR};
          outRequest <= 1'b1;
        end
        HEAD2, DATA: if (accepted) begin
          crc <= crcNext;
          cnt <= (state == HEAD2) ? 8'd0 : cnt + 8'd1;
          state <= lastWord ? CRC : FETCH;
          outData <= lastWord ? crcNext : outData;
          outRequest <= lastWord;
          dataRd <= !lastWord;
        end
        FETCH: if (!dataRd && bus.data_vld) begin
          state <= DATA;
          outData <= bus.data_in;
          outRequest <= 1'b1;
        end
        CRC: if (accepted) begin
          state <= NUM;
          outData <= num;
          outRequest <= 1'b1;
        end
        NUM: if (accepted) begin
          state <= IDLE;
          busyR <= 1'b0;
          pktDone <= 1'b1;
          num <= num + 16'd1;
        end
        default: state <= IDLE;
      endcase
`ifdef SP_PACKER_TIMEOUT_EN
      pktErr <= 1'b0;
      tmo <= waiting ? tmo + 16'd1 : 16'd0;
      if (waiting && tmo == 16'(TIMEOUT - 1)) begin
        state <= IDLE;
        busyR <= 1'b0;
        pktErr <= 1'b1;
        tmo <= '0;
      end
`endif
    end
  end
  assign bus.out_data = outData;
  assign bus.out_request = outRequest;
  assign bus.data_rd = dataRd;
  assign bus.busy = busyR;
  assign bus.pkt_done = pktDone;
`ifdef SP_PACKER_TIMEOUT_EN
  assign bus.pkt_err = pktErr;
`else
  assign bus.pkt_err = 1'b0;
`endif
endmodule
